// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM encoding, reference clock rate
// and a helper for deriving the expected count window.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StGate = 2'd2,
    StDone = 2'd3
  } meter_state_e;

  localparam int unsigned REF_CLK_HZ = 50_000_000;

  // Expected edge count bound for a target clock seen through a divide-by-2 toggle flop.
  function automatic longint unsigned expect_bound(longint unsigned target_hz,
                                                   longint unsigned gate_cycles,
                                                   longint unsigned tol_ppm,
                                                   bit              upper);
    longint unsigned nominal;
    longint unsigned delta;
    nominal = (target_hz / 2) * gate_cycles / longint'(REF_CLK_HZ);
    delta   = nominal * tol_ppm / 1_000_000;
    return upper ? nominal + delta : nominal - delta;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser chain plus previous-value flop; emits a one-cycle pulse per rising edge
// of an asynchronous input.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of meas_in over a fixed inclk0 gate window and publishes the count
// with a range/overflow verdict.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned EXPECT_MIN  = 4990,
  parameter int unsigned EXPECT_MAX  = 5010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   inclk0,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   meas_in,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   count_valid,
  output logic                   in_range,
  output logic                   overflow
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned ArmW  = $clog2(SYNC_STAGES + 1);

  meter_state_e           state_q, state_d;
  logic [ArmW-1:0]        arm_cnt_q, arm_cnt_d;
  logic [GateW-1:0]       gate_cnt_q, gate_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   enter_arm;
  logic                   publish;
  logic                   edge_pulse;
  logic                   hit;
  logic                   busy_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   in_range_q;
  logic                   overflow_q;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk        (inclk0),
    .rst        (areset),
    .din        (meas_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    enter_arm  = 1'b0;
    publish    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) enter_arm = 1'b1;
      end
      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else if (arm_cnt_q == '0) begin
          state_d    = StGate;
          gate_cnt_d = GateW'(GATE_CYCLES - 1);
        end else begin
          arm_cnt_d = arm_cnt_q - ArmW'(1);
        end
      end
      StGate: begin
        if (edge_pulse) begin
          if (&edge_cnt_q) ovf_d = 1'b1;
          else             edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
        end
        if (abort) begin
          state_d = StIdle;
        end else if (gate_cnt_q == '0) begin
          state_d = StDone;
          publish = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q - GateW'(1);
        end
      end
      StDone: begin
        // A held start re-arms straight away so runs follow back to back.
        if (start && !abort) enter_arm = 1'b1;
        else                 state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (enter_arm) begin
      state_d    = StArm;
      arm_cnt_d  = ArmW'(SYNC_STAGES);
      edge_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  assign hit = (32'(edge_cnt_d) >= EXPECT_MIN) && (32'(edge_cnt_d) <= EXPECT_MAX);

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      arm_cnt_q  <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
      in_range_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= (state_d != StIdle);
      if (publish) begin
        count_q    <= edge_cnt_d;
        overflow_q <= ovf_d;
        in_range_q <= hit && !ovf_d;
      end
    end
  end

  assign busy        = busy_q;
  assign count       = count_q;
  assign count_valid = (state_q == StDone);
  assign in_range    = in_range_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (8-bit and 4-bit counters) share random stimulus
// and are checked against a timestamp-based edge-counting model.
module tb_clk_freq_meter;

  localparam int unsigned Gate = 100;
  localparam int unsigned Lat  = Gate + 4;  // cycle start is driven -> cycle of count_valid

  logic       inclk0 = 1'b0;
  logic       areset;
  logic       start;
  logic       abort;
  logic       meas_in = 1'b0;
  logic       busy8, cv8, ir8, ov8;
  logic [7:0] count8;
  logic       busy4, cv4, ir4, ov4;
  logic [3:0] count4;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned gen_period = 10;
  int unsigned gen_high   = 5;
  int unsigned gen_phase  = 0;
  int unsigned rise_q[$];
  logic [9:0]  exp8;
  logic [5:0]  exp4;

  clk_freq_meter #(
    .GATE_CYCLES (Gate),
    .COUNT_WIDTH (8),
    .EXPECT_MIN  (9),
    .EXPECT_MAX  (11),
    .SYNC_STAGES (2)
  ) u_dut8 (
    .inclk0      (inclk0),
    .areset      (areset),
    .start       (start),
    .abort       (abort),
    .meas_in     (meas_in),
    .busy        (busy8),
    .count       (count8),
    .count_valid (cv8),
    .in_range    (ir8),
    .overflow    (ov8)
  );

  clk_freq_meter #(
    .GATE_CYCLES (Gate),
    .COUNT_WIDTH (4),
    .EXPECT_MIN  (9),
    .EXPECT_MAX  (11),
    .SYNC_STAGES (2)
  ) u_dut4 (
    .inclk0      (inclk0),
    .areset      (areset),
    .start       (start),
    .abort       (abort),
    .meas_in     (meas_in),
    .busy        (busy4),
    .count       (count4),
    .count_valid (cv4),
    .in_range    (ir4),
    .overflow    (ov4)
  );

  always #5 inclk0 = ~inclk0;

  // Signal generator; logs the cycle in which each rising edge of meas_in appears.
  initial begin
    forever begin
      @(posedge inclk0);
      cyc++;
      #1;
      gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
      if (gen_phase < gen_high && meas_in !== 1'b1) rise_q.push_back(cyc);
      meas_in = (gen_phase < gen_high);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge inclk0);
    #2;
  endtask

  function automatic int unsigned count_rises(int unsigned lo, int unsigned hi);
    int unsigned n;
    n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
    return n;
  endfunction

  // Start driven in cycle j: the gate sees meas_in rises from cycles j+2 .. j+1+Gate.
  task automatic set_expect(input int unsigned j);
    int unsigned raw;
    raw  = count_rises(j + 2, j + 1 + Gate);
    exp8 = {(raw > 255) ? 8'd255 : 8'(raw), (raw <= 255) && raw >= 9 && raw <= 11, raw > 255};
    exp4 = {(raw > 15) ? 4'd15 : 4'(raw), (raw <= 15) && raw >= 9 && raw <= 11, raw > 15};
  endtask

  task automatic run_one(input int unsigned period, input int unsigned high, input string tag);
    int unsigned j;
    gen_period = period;
    gen_high   = high;
    repeat ($urandom_range(12, 3)) tick();
    start = 1'b1;
    j     = cyc;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy8, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s busy_rise: got %b want 11", tag, {busy8, busy4});
    end
    while (cv8 !== 1'b1 && cyc < j + 300) tick();
    set_expect(j);
    n_checks++;
    if (cyc - j !== Lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc - j, Lat);
    end
    n_checks++;
    if ({count8, ir8, ov8} !== exp8) begin
      n_fail++;
      $display("FAIL %s result8: got cnt=%0d ir=%b ov=%b want cnt=%0d ir=%b ov=%b", tag,
               count8, ir8, ov8, exp8[9:2], exp8[1], exp8[0]);
    end
    n_checks++;
    if ({cv4, count4, ir4, ov4} !== {1'b1, exp4}) begin
      n_fail++;
      $display("FAIL %s result4: got cv=%b cnt=%0d ir=%b ov=%b want cv=1 cnt=%0d ir=%b ov=%b",
               tag, cv4, count4, ir4, ov4, exp4[5:2], exp4[1], exp4[0]);
    end
    tick();
    n_checks++;
    if ({busy8, cv8, busy4, cv4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s busy_fall: got %b want 0000", tag, {busy8, cv8, busy4, cv4});
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy8, count8, cv8, ir8, ov8} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got %h want 000", {busy8, count8, cv8, ir8, ov8});
    end
    n_checks++;
    if ({busy4, count4, cv4, ir4, ov4} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got %h want 00", {busy4, count4, cv4, ir4, ov4});
    end
    areset = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({busy8, cv8, busy4, cv4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0000", {busy8, cv8, busy4, cv4});
    end
  endtask

  task automatic test_measure();
    int unsigned p;
    run_one(10, 5, "period10");
    run_one(4, 2, "period4");
    run_one(20, 10, "period20");
    run_one(2, 1, "period2_sat");
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(24, 2);
      run_one(p, $urandom_range(p - 1, 1), "random");
    end
  endtask

  task automatic test_abort();
    int unsigned j;
    bit          seen;
    run_one(10, 5, "abort_pre");
    start = 1'b1;
    j     = cyc;
    tick();
    start = 1'b0;
    while (cyc < j + 54) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy8, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 00", {busy8, busy4});
    end
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (cv8 !== 1'b0 || cv4 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got pulse=%b want 0", seen);
    end
    n_checks++;
    if ({count8, ir8, ov8} !== exp8 || {count4, ir4, ov4} !== exp4) begin
      n_fail++;
      $display("FAIL abort_hold: got cnt8=%0d ir8=%b cnt4=%0d ir4=%b want cnt8=%0d ir8=%b cnt4=%0d ir4=%b",
               count8, ir8, count4, ir4, exp8[9:2], exp8[1], exp4[5:2], exp4[1]);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({busy8, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_priority: got busy=%b want 00", {busy8, busy4});
    end
  endtask

  task automatic test_start_ignored();
    int unsigned j;
    bit          seen;
    gen_period = $urandom_range(16, 3);
    gen_high   = $urandom_range(gen_period - 1, 1);
    tick();
    start = 1'b1;
    j     = cyc;
    tick();
    start = 1'b0;
    while (cyc < j + 40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cv8 !== 1'b1 && cyc < j + 300) tick();
    set_expect(j);
    n_checks++;
    if (cyc - j !== Lat) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d want %0d", cyc - j, Lat);
    end
    n_checks++;
    if ({count8, ir8, ov8} !== exp8) begin
      n_fail++;
      $display("FAIL ignore_result8: got cnt=%0d ir=%b ov=%b want cnt=%0d ir=%b ov=%b",
               count8, ir8, ov8, exp8[9:2], exp8[1], exp8[0]);
    end
    seen = 1'b0;
    tick();
    if (busy8 !== 1'b0) seen = 1'b1;
    repeat (120) begin
      tick();
      if (cv8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_rerun: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned j;
    gen_period = $urandom_range(14, 6);
    gen_high   = $urandom_range(gen_period - 1, 1);
    tick();
    start = 1'b1;
    j     = cyc;
    for (int k = 0; k < 3; k++) begin
      tick();
      while (cv8 !== 1'b1 && cyc < j + 300) tick();
      if (k == 2) start = 1'b0;
      set_expect(j);
      n_checks++;
      if (cyc - j !== Lat) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d want %0d", k, cyc - j, Lat);
      end
      n_checks++;
      if ({count8, ir8, ov8} !== exp8 || {count4, ir4, ov4} !== exp4) begin
        n_fail++;
        $display("FAIL b2b_result%0d: got cnt8=%0d cnt4=%0d ov4=%b want cnt8=%0d cnt4=%0d ov4=%b",
                 k, count8, count4, ov4, exp8[9:2], exp4[5:2], exp4[0]);
      end
      j = cyc;
    end
    tick();
    n_checks++;
    if ({busy8, cv8} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_stop: got busy/cv=%b want 00", {busy8, cv8});
    end
  endtask

  task automatic test_async_reset();
    int unsigned j;
    bit          seen;
    run_one(10, 5, "areset_pre");
    start = 1'b1;
    j     = cyc;
    tick();
    start = 1'b0;
    while (cyc < j + 50) tick();
    #3;
    areset = 1'b1;
    #1;
    n_checks++;
    if ({busy8, count8, cv8, ir8, ov8} !== 12'd0 || {busy4, count4, cv4, ir4, ov4} !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_async: got dut8=%h dut4=%h want 000/00",
               {busy8, count8, cv8, ir8, ov8}, {busy4, count4, cv4, ir4, ov4});
    end
    tick();
    areset = 1'b0;
    seen   = 1'b0;
    repeat (150) begin
      tick();
      if (busy8 !== 1'b0 || cv8 !== 1'b0 || busy4 !== 1'b0 || cv4 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_stays_idle: got activity=%b want 0", seen);
    end
    run_one(10, 5, "areset_post");
  endtask

  initial begin
    areset = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    repeat (3) tick();
    test_reset();
    test_measure();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
